// File: rtl/red_fxp_pipe_if.sv
// Stream bundle for the fixed-point precision reducer.
// Carries the input word handshake and the output word handshake.
// The design sits on the slave side. The environment (upstream producer plus
// downstream consumer) sits on the master side.
interface red_fxp_pipe_if #(
    parameter int I_PREC = 32,
    parameter int O_PREC = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [I_PREC-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [O_PREC-1:0] out_data;
    logic              out_sat;

    // Environment view: drives the input word and the output acceptance.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    // Converter view.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat
    );
endinterface

// File: rtl/red_fxp_pipe.sv
// Streaming fixed-point precision reducer (for example Q16.16 -> Q8.8).
// S1 drops D = I_FRAC-O_FRAC fraction bits and rounds to nearest, with ties
// going to even. The rounded value keeps one extra bit so the rounding carry
// is never lost. S2 clips that value to the output range and flags the clip.
// Each stage holds one word and is guarded by a valid bit. A full stall
// therefore holds two words. The module also keeps a sticky saturating count
// of clipped words that are handed to the consumer.
module red_fxp_pipe #(
    parameter int SIGN   = 1,
    parameter int I_PREC = 32,
    parameter int I_FRAC = 16,
    parameter int O_PREC = 16,
    parameter int O_FRAC = 8,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_,
    red_fxp_pipe_if.slave     bus,
    input  logic              scnt_clr,
    output logic [SCNT_W-1:0] sat_count
);

    // Number of discarded fraction bits.
    localparam int D  = I_FRAC - O_FRAC;
    // Width of the bits that remain after the shift.
    localparam int KW = I_PREC - D;
    // Rounded width, with one extra bit to keep the rounding carry.
    localparam int RW = KW + 1;

    // Reject configurations that would need to widen the fraction or the
    // integer part. Widening is the job of the companion converter.
    generate
        if ((I_FRAC < O_FRAC) || ((I_PREC - I_FRAC) < (O_PREC - O_FRAC))) begin : g_bad_cfg
            $fatal(1, "red_fxp_pipe: requires I_FRAC>=O_FRAC and I_PREC-I_FRAC>=O_PREC-O_FRAC");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic              s1_valid_q, s1_valid_d;
    logic [RW-1:0]     s1_r_q,     s1_r_d;
    logic              s2_valid_q, s2_valid_d;
    logic [O_PREC-1:0] s2_data_q,  s2_data_d;
    logic              s2_sat_q,   s2_sat_d;
    logic [SCNT_W-1:0] scnt_q,     scnt_d;

    // Handshake control. No path exists from in_valid to out_valid.
    logic s2_adv;
    logic s1_adv;
    logic out_xfer;

    assign s2_adv   = bus.out_ready || !s2_valid_q;
    assign s1_adv   = s2_adv || !s2_valid_q;
    assign out_xfer = s2_valid_q && bus.out_ready;

    assign bus.in_ready  = s1_adv || !s1_valid_q;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_sat   = s2_sat_q;
    assign sat_count     = scnt_q;

    // ------------------------------------------------------------------
    // S1: round to nearest, ties to even
    // ------------------------------------------------------------------
    logic [RW-1:0] round_val;

    generate
        if (D == 0) begin : g_no_round
            // No fraction bits are dropped. The word is only extended by one bit.
            assign round_val = {((SIGN != 0) ? bus.in_data[I_PREC-1] : 1'b0), bus.in_data};
        end else begin : g_round
            logic [KW-1:0] kept;
            logic          guard_bit;
            logic          sticky_bit;
            logic          ext_bit;
            logic          round_up;

            assign kept      = bus.in_data[I_PREC-1:D];
            assign guard_bit = bus.in_data[D-1];

            // The sticky bit only exists when at least two bits are dropped.
            if (D >= 2) begin : g_sticky
                assign sticky_bit = |bus.in_data[D-2:0];
            end else begin : g_no_sticky
                assign sticky_bit = 1'b0;
            end

            assign ext_bit  = (SIGN != 0) ? kept[KW-1] : 1'b0;
            // Round up above half. At exactly half, round up only when the
            // kept LSB is odd, so the result lands on the even value.
            assign round_up = guard_bit & (sticky_bit | kept[0]);
            // An arithmetic shift plus the extension bit means adding round_up
            // can never overflow the RW-bit result.
            assign round_val = {ext_bit, kept} + {{(RW-1){1'b0}}, round_up};
        end
    endgenerate

    // ------------------------------------------------------------------
    // S2: clip the rounded value to the output range
    // ------------------------------------------------------------------
    logic [O_PREC-1:0] clip_data;
    logic              clip_flag;

    generate
        if (SIGN != 0) begin : g_sat_signed
            logic [RW-O_PREC:0] upper;
            logic               ovf;
            logic               neg;

            // The value fits when every bit from the output sign bit upward agrees.
            assign upper = s1_r_q[RW-1:O_PREC-1];
            assign ovf   = !((&upper) || (~|upper));
            assign neg   = s1_r_q[RW-1];

            // Choose the most negative or most positive code when out of range.
            always_comb begin
                clip_flag = ovf;
                clip_data = s1_r_q[O_PREC-1:0];
                if (ovf) begin
                    clip_data = neg ? {1'b1, {(O_PREC-1){1'b0}}}
                                    : {1'b0, {(O_PREC-1){1'b1}}};
                end
            end
        end else begin : g_sat_unsigned
            logic ovf;

            // An unsigned value can never fall below zero, so only the top of
            // the range needs checking.
            assign ovf = |s1_r_q[RW-1:O_PREC];

            // Clamp to all-ones when the value exceeds the output width.
            always_comb begin
                clip_flag = ovf;
                clip_data = ovf ? {O_PREC{1'b1}} : s1_r_q[O_PREC-1:0];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // S1 loads a new word (or a bubble) whenever the input side is ready.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_r_d     = s1_r_q;
        if (bus.in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_r_d = round_val;
            end
        end
    end

    // S2 takes from S1 when it advances. Otherwise it holds, which keeps the
    // output stable during a stall.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = clip_data;
                s2_sat_d  = clip_flag;
            end
        end
    end

    // Saturation-event counter. It counts only clipped words that are handed
    // to the consumer. It stops at all-ones, and a clear always wins.
    always_comb begin
        scnt_d = scnt_q;
        if (scnt_clr) begin
            scnt_d = '0;
        end else if (out_xfer && s2_sat_q && !(&scnt_q)) begin
            scnt_d = scnt_q + {{(SCNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Pipeline registers. An asynchronous reset flushes any word in flight.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

endmodule

// File: tb/tb_red_fxp_pipe.sv
// Directed testbench for red_fxp_pipe in its default Q16.16 -> Q8.8 signed
// configuration. Each scenario task drives its own stimulus and checks the
// results against hand-computed values.
module tb_red_fxp_pipe;

    logic        clk;
    logic        reset_;
    logic        scnt_clr;
    logic [15:0] sat_count;

    int checks   = 0;
    int failures = 0;

    red_fxp_pipe_if #(.I_PREC(32), .O_PREC(16)) bus ();

    red_fxp_pipe #(
        .SIGN(1), .I_PREC(32), .I_FRAC(16), .O_PREC(16), .O_FRAC(8), .SCNT_W(16)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .bus      (bus),
        .scnt_clr (scnt_clr),
        .sat_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word into an idle pipeline and collect the first output.
    // lat counts clock edges from the cycle the word is presented until out_valid is seen.
    task automatic pass_word(input logic [31:0] din, output logic [15:0] dout,
                             output logic dsat, output int lat, output bit ok);
        int guard;
        ok   = 1'b0;
        dout = '0;
        dsat = 1'b0;
        lat  = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = din;
        bus.out_ready = 1'b1;
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 10) begin
            tick();
            guard++;
        end
        tick();
        lat = 1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        if (bus.out_valid) begin
            ok   = 1'b1;
            dout = bus.out_data;
            dsat = bus.out_sat;
            $display("xfer in=%08h out=%04h sat=%0b lat=%0d", din, dout, dsat, lat);
            tick();
        end
    endtask

    // Check the outputs during reset and just after it is released.
    task automatic test_reset();
        reset_        = 1'b0;
        scnt_clr      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #13;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b data=%h sat=%b expected 0/0000/0",
                     bus.out_valid, bus.out_data, bus.out_sat);
        end
        checks++;
        if (sat_count !== 16'h0000) begin
            failures++;
            $display("FAIL reset_scnt: got %h expected 0000", sat_count);
        end
        reset_ = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    // Send a value that needs no rounding and check the latency.
    task automatic test_exact();
        logic [15:0] d; logic s; int lat; bit ok;
        pass_word(32'h0001_8000, d, s, lat, ok);
        checks++;
        if (!ok || d !== 16'h0180 || s !== 1'b0) begin
            failures++;
            $display("FAIL exact_1p5: ok=%0b got %h sat=%b expected 0180 sat=0", ok, d, s);
        end
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL exact_latency: got %0d expected 2", lat);
        end
    endtask

    // Check round-to-nearest with ties going to even, for both signs.
    task automatic test_ties();
        logic [31:0] vin[7];
        logic [15:0] vexp[7];
        logic [15:0] d; logic s; int lat; bit ok;
        vin  = '{32'h0000_0080, 32'h0000_0180, 32'hFFFF_FF80, 32'h0000_00C0,
                 32'h0000_0280, 32'hFFFF_FE80, 32'hFFFF_FF40};
        vexp = '{16'h0000, 16'h0002, 16'h0000, 16'h0001,
                 16'h0002, 16'hFFFE, 16'hFFFF};
        for (int i = 0; i < 7; i++) begin
            pass_word(vin[i], d, s, lat, ok);
            checks++;
            if (!ok || d !== vexp[i] || s !== 1'b0) begin
                failures++;
                $display("FAIL tie_%0d: in=%h ok=%0b got %h sat=%b expected %h sat=0",
                         i, vin[i], ok, d, s, vexp[i]);
            end
        end
    endtask

    // Check clipping at both ends, the rounding-carry overflow, and exact bounds.
    task automatic test_saturation();
        logic [31:0] vin[5];
        logic [15:0] vexp[5];
        logic        vsat[5];
        logic [15:0] d; logic s; int lat; bit ok;
        vin  = '{32'h0080_0000, 32'hFF38_0000, 32'h007F_FF80, 32'h007F_FF00, 32'hFF80_0000};
        vexp = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000};
        vsat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            pass_word(vin[i], d, s, lat, ok);
            checks++;
            if (!ok || d !== vexp[i] || s !== vsat[i]) begin
                failures++;
                $display("FAIL sat_%0d: in=%h ok=%0b got %h sat=%b expected %h sat=%b",
                         i, vin[i], ok, d, s, vexp[i], vsat[i]);
            end
        end
        checks++;
        if (sat_count !== 16'd3) begin
            failures++;
            $display("FAIL sat_count_3: got %0d expected 3", sat_count);
        end
    endtask

    // Send 6 words back to back while the consumer stalls for cycles 2..5.
    task automatic test_back_to_back();
        logic [31:0] win[6];
        logic [15:0] wexp[6];
        logic        wsat[6];
        int sent = 0, recv = 0, cyc = 0, low_cnt = 0;
        bit stalled_prev = 1'b0;
        logic [15:0] held_d = '0;
        logic        held_s = 1'b0;
        win  = '{32'h0001_0000, 32'h0002_0080, 32'h0003_0180,
                 32'hFFFF_0000, 32'h0080_0000, 32'h0005_0040};
        wexp = '{16'h0100, 16'h0200, 16'h0302, 16'hFF00, 16'h7FFF, 16'h0500};
        wsat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        while (recv < 6 && cyc < 40) begin
            bus.in_valid  = (sent < 6);
            bus.in_data   = (sent < 6) ? win[sent] : 32'h0;
            bus.out_ready = !(cyc >= 2 && cyc <= 5);
            #1;
            if (stalled_prev) begin
                checks++;
                if (bus.out_data !== held_d || bus.out_sat !== held_s || bus.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold cyc%0d: got %h/%b/%b expected %h/%b/1",
                             cyc, bus.out_data, bus.out_sat, bus.out_valid, held_d, held_s);
                end
            end
            if (!bus.in_ready) begin
                low_cnt++;
                checks++;
                if (sent - recv != 2) begin
                    failures++;
                    $display("FAIL bp_ready_low cyc%0d: held %0d words expected 2", cyc, sent - recv);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                $display("xfer bp out[%0d]=%04h sat=%0b cyc=%0d", recv, bus.out_data, bus.out_sat, cyc);
                checks++;
                if (bus.out_data !== wexp[recv] || bus.out_sat !== wsat[recv]) begin
                    failures++;
                    $display("FAIL bp_out_%0d: got %h sat=%b expected %h sat=%b",
                             recv, bus.out_data, bus.out_sat, wexp[recv], wsat[recv]);
                end
                recv++;
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
            held_s = bus.out_sat;
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (recv !== 6 || sent !== 6) begin
            failures++;
            $display("FAIL bp_count: sent=%0d recv=%0d expected 6/6", sent, recv);
        end
        checks++;
        if (low_cnt !== 4) begin
            failures++;
            $display("FAIL bp_ready_cycles: in_ready low %0d cycles expected 4", low_cnt);
        end
        checks++;
        if (sat_count !== 16'd4) begin
            failures++;
            $display("FAIL bp_scnt: got %0d expected 4", sat_count);
        end
    endtask

    // Check that the counter clears, stops at all-ones, and that a clear wins
    // over a same-cycle saturating transfer.
    task automatic test_counter();
        int n = 65539;
        int sent = 0, recv = 0, cyc = 0;
        bit mid_done = 1'b0;
        scnt_clr = 1'b1;
        tick();
        scnt_clr = 1'b0;
        checks++;
        if (sat_count !== 16'h0000) begin
            failures++;
            $display("FAIL scnt_clear: got %h expected 0000", sat_count);
        end
        bus.in_data   = 32'h0080_0000;
        bus.out_ready = 1'b1;
        while (recv < n && cyc < n + 100) begin
            bus.in_valid = (sent < n);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) recv++;
            tick();
            cyc++;
            if (recv == 10 && !mid_done) begin
                mid_done = 1'b1;
                checks++;
                if (sat_count !== 16'd10) begin
                    failures++;
                    $display("FAIL scnt_10: got %0d expected 10", sat_count);
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (recv !== n) begin
            failures++;
            $display("FAIL scnt_stream: received %0d expected %0d", recv, n);
        end
        checks++;
        if (sat_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL scnt_hold: got %h expected ffff", sat_count);
        end
        // Load two saturating words, then assert clear as the first one transfers.
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        scnt_clr = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sat !== 1'b1) begin
            failures++;
            $display("FAIL scnt_clr_setup: valid=%b sat=%b expected 1/1", bus.out_valid, bus.out_sat);
        end
        tick();
        scnt_clr = 1'b0;
        checks++;
        if (sat_count !== 16'h0000) begin
            failures++;
            $display("FAIL scnt_clr_wins: got %h expected 0000", sat_count);
        end
        tick();
        checks++;
        if (sat_count !== 16'h0001) begin
            failures++;
            $display("FAIL scnt_after_clr: got %h expected 0001", sat_count);
        end
        tick();
        tick();
    endtask

    // Assert reset with two words in flight, then check that the pipeline
    // recovers with a fresh word.
    task automatic test_reset_midstream();
        logic [15:0] d; logic s; int lat; bit ok;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0080_0000;
        tick();
        bus.in_data   = 32'h0001_0000;
        tick();
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || sat_count !== 16'h0001) begin
            failures++;
            $display("FAIL rst_setup: valid=%b scnt=%h expected 1/0001", bus.out_valid, sat_count);
        end
        #2;
        reset_ = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_sat !== 1'b0 || bus.out_data !== 16'h0000) begin
            failures++;
            $display("FAIL rst_async_out: valid=%b data=%h sat=%b expected 0/0000/0",
                     bus.out_valid, bus.out_data, bus.out_sat);
        end
        checks++;
        if (sat_count !== 16'h0000) begin
            failures++;
            $display("FAIL rst_async_scnt: got %h expected 0000", sat_count);
        end
        @(negedge clk);
        reset_ = 1'b1;
        tick();
        pass_word(32'h0001_8000, d, s, lat, ok);
        checks++;
        if (!ok || d !== 16'h0180 || s !== 1'b0 || lat !== 2) begin
            failures++;
            $display("FAIL rst_recover: ok=%0b got %h sat=%b lat=%0d expected 0180 sat=0 lat=2",
                     ok, d, s, lat);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_ties();
        test_saturation();
        test_back_to_back();
        test_counter();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
